// File: rtl/b_train_accum.sv
// B-train pulse integrator feeding the B->F frequency calculator.
// Integrates up/down/zero pulses into a 32-bit field word and issues a snapshot on each update tick.
module b_train_accum #(
   parameter logic [31:0] B_STEP     = 32'd336,
   parameter logic [31:0] B_INIT     = 32'd0,
   parameter int unsigned UPDATE_DIV = 100,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        b_up,
   input  logic        b_down,
   input  logic        b_zero,
   input  logic [31:0] b_preset,
   input  logic        enable,
   input  logic        clear_flags,
   input  logic        calc_ready,
   output logic [31:0] b_field,
   output logic        start,
   output logic        busy,
   output logic [3:0]  flags
);

   localparam int unsigned DIV_W   = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
   localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);
   localparam int unsigned PIN_W   = 3;
   localparam int unsigned PIN_UP  = 0;
   localparam int unsigned PIN_DN  = 1;
   localparam int unsigned PIN_ZR  = 2;
   localparam int unsigned FLG_OVF = 0;
   localparam int unsigned FLG_UDF = 1;
   localparam int unsigned FLG_OVR = 2;
   localparam int unsigned FLG_TMO = 3;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WAIT_LOW  = 2'd1;
   localparam logic [1:0] ST_WAIT_HIGH = 2'd2;

   logic [PIN_W-1:0] sync1_q, sync2_q, edge_q;
   logic [PIN_W-1:0] rise_c;
   logic [31:0]      acc_q, acc_d;
   logic [32:0]      sum_c;
   logic             ovf_set_c, udf_set_c;
   logic [DIV_W-1:0] div_q, div_d;
   logic             tick_c;
   logic [1:0]       state_q, state_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             tmo_expired_c;
   logic             pending_q, pending_d;
   logic             tmo_set_c, ovr_set_c;
   logic [31:0]      b_field_q, b_field_d;
   logic             start_q, start_d;
   logic             busy_q, busy_d;
   logic [3:0]       flags_q, flags_d;

   assign rise_c = sync2_q & ~edge_q;
   assign sum_c  = {1'b0, acc_q} + {1'b0, B_STEP};

   // Accumulator: zero marker dominates, coincident up/down cancel, saturate at both ends.
   always_comb begin
      acc_d     = acc_q;
      ovf_set_c = 1'b0;
      udf_set_c = 1'b0;
      if (rise_c[PIN_ZR]) begin
         acc_d = b_preset;
      end else if (rise_c[PIN_UP] && !rise_c[PIN_DN]) begin
         if (sum_c[32]) begin
            acc_d     = 32'hFFFF_FFFF;
            ovf_set_c = 1'b1;
         end else begin
            acc_d = sum_c[31:0];
         end
      end else if (rise_c[PIN_DN] && !rise_c[PIN_UP]) begin
         if (acc_q < B_STEP) begin
            acc_d     = 32'd0;
            udf_set_c = 1'b1;
         end else begin
            acc_d = acc_q - B_STEP;
         end
      end
   end

   // Update-rate prescaler; parked at zero while disabled.
   always_comb begin
      tick_c = enable && (div_q == DIV_W'(UPDATE_DIV - 1));
      div_d  = '0;
      if (enable && !tick_c) begin
         div_d = div_q + DIV_W'(1);
      end
   end

   // Handshake FSM with per-state timeout and a single-deep pending request.
   always_comb begin
      state_d       = state_q;
      pending_d     = pending_q;
      b_field_d     = b_field_q;
      start_d       = 1'b0;
      tmo_set_c     = 1'b0;
      ovr_set_c     = 1'b0;
      tmo_expired_c = (tmo_q == TMO_W'(TIMEOUT - 1));

      case (state_q)
         ST_IDLE: begin
            if (tick_c || pending_q) begin
               b_field_d = acc_d;
               start_d   = 1'b1;
               pending_d = 1'b0;
               state_d   = ST_WAIT_LOW;
            end
         end
         ST_WAIT_LOW: begin
            if (!calc_ready) begin
               state_d = ST_WAIT_HIGH;
            end else if (tmo_expired_c) begin
               tmo_set_c = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_WAIT_HIGH: begin
            if (calc_ready) begin
               state_d = ST_IDLE;
            end else if (tmo_expired_c) begin
               tmo_set_c = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if ((state_q != ST_IDLE) && tick_c && !pending_q) begin
         pending_d = 1'b1;
         ovr_set_c = 1'b1;
      end

      if ((state_d != state_q) || (state_q == ST_IDLE)) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + TMO_W'(1);
      end

      busy_d = (state_d != ST_IDLE);
   end

   // Sticky flags: a set in the same cycle as clear_flags survives.
   always_comb begin
      flags_d = clear_flags ? 4'b0000 : flags_q;
      flags_d[FLG_OVF] = flags_d[FLG_OVF] | ovf_set_c;
      flags_d[FLG_UDF] = flags_d[FLG_UDF] | udf_set_c;
      flags_d[FLG_OVR] = flags_d[FLG_OVR] | ovr_set_c;
      flags_d[FLG_TMO] = flags_d[FLG_TMO] | tmo_set_c;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         edge_q    <= '0;
         acc_q     <= B_INIT;
         div_q     <= '0;
         state_q   <= ST_IDLE;
         tmo_q     <= '0;
         pending_q <= 1'b0;
         b_field_q <= B_INIT;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
         flags_q   <= 4'b0000;
      end else begin
         sync1_q   <= {b_zero, b_down, b_up};
         sync2_q   <= sync1_q;
         edge_q    <= sync2_q;
         acc_q     <= acc_d;
         div_q     <= div_d;
         state_q   <= state_d;
         tmo_q     <= tmo_d;
         pending_q <= pending_d;
         b_field_q <= b_field_d;
         start_q   <= start_d;
         busy_q    <= busy_d;
         flags_q   <= flags_d;
      end
   end

   assign b_field = b_field_q;
   assign start   = start_q;
   assign busy    = busy_q;
   assign flags   = flags_q;

endmodule

// File: tb/tb_b_train_accum.sv
// Bench for b_train_accum: random pulse trains against an arithmetic field model plus a calculator responder.
module tb_b_train_accum;

   localparam longint B_STEP  = 336;
   localparam longint ACC_MAX = 64'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        b_up, b_down, b_zero;
   logic [31:0] b_preset;
   logic        enable, clear_flags, calc_ready;
   logic [31:0] b_field;
   logic        start, busy;
   logic [3:0]  flags;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int width_err = 0;
   logic prev_start = 1'b0;

   longint     m_acc;
   logic [3:0] m_flags;

   // Calculator responder: 0 = normal (ack delay then latency), 1 = ready stuck high, 2 = stuck low
   int rsp_mode = 0;
   int rsp_ack  = 0;
   int rsp_lat  = 11;
   int rsp_cnt  = 0;

   b_train_accum dut (
      .clk        (clk),
      .reset      (reset),
      .b_up       (b_up),
      .b_down     (b_down),
      .b_zero     (b_zero),
      .b_preset   (b_preset),
      .enable     (enable),
      .clear_flags(clear_flags),
      .calc_ready (calc_ready),
      .b_field    (b_field),
      .start      (start),
      .busy       (busy),
      .flags      (flags)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (start === 1'b1 && prev_start === 1'b1) width_err++;
      prev_start = start;
   end

   always @(negedge clk) begin
      if (rsp_mode == 1) begin
         calc_ready = 1'b1;
         rsp_cnt    = 0;
      end else if (rsp_mode == 2) begin
         calc_ready = 1'b0;
         rsp_cnt    = 0;
      end else begin
         if (start === 1'b1) rsp_cnt = 1;
         else if (rsp_cnt != 0) rsp_cnt++;
         if (rsp_cnt == 0) begin
            calc_ready = 1'b1;
         end else if (rsp_cnt > rsp_ack + rsp_lat) begin
            calc_ready = 1'b1;
            rsp_cnt    = 0;
         end else if (rsp_cnt > rsp_ack) begin
            calc_ready = 1'b0;
         end else begin
            calc_ready = 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic m_up();
      if (m_acc + B_STEP > ACC_MAX) begin
         m_acc      = ACC_MAX;
         m_flags[0] = 1'b1;
      end else begin
         m_acc = m_acc + B_STEP;
      end
   endtask

   task automatic m_dn();
      if (m_acc < B_STEP) begin
         m_acc      = 0;
         m_flags[1] = 1'b1;
      end else begin
         m_acc = m_acc - B_STEP;
      end
   endtask

   // One pulse of 3 cycles high, 3 low on the selected pins, then fold it into the model.
   task automatic pulse(input logic u, input logic d, input logic z);
      b_up = u; b_down = d; b_zero = z;
      repeat (3) @(negedge clk);
      b_up = 1'b0; b_down = 1'b0; b_zero = 1'b0;
      repeat (3) @(negedge clk);
      if (z) m_acc = longint'(b_preset);
      else if (u && !d) m_up();
      else if (d && !u) m_dn();
   endtask

   task automatic wait_start(input int max_cyc, output int c);
      logic seen;
      seen = 1'b0;
      c = -1;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         @(negedge clk);
         if (start === 1'b1) begin
            seen = 1'b1;
            c = cyc;
         end
      end
      chk("start_seen", 32'(seen), 32'd1);
   endtask

   task automatic wait_tmo(input int max_cyc, output int c);
      logic seen;
      seen = 1'b0;
      c = -1;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         @(negedge clk);
         if (flags[3] === 1'b1) begin
            seen = 1'b1;
            c = cyc;
         end
      end
      chk("timeout_seen", 32'(seen), 32'd1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("idle", 32'(busy), 32'd0);
   endtask

   task automatic do_clear();
      clear_flags = 1'b1;
      @(negedge clk);
      clear_flags = 1'b0;
      m_flags = 4'b0000;
   endtask

   initial begin
      int   c0, cs, prev, tc, npulse;
      logic u;

      reset = 1'b1; enable = 1'b0; clear_flags = 1'b0;
      b_up = 1'b0; b_down = 1'b0; b_zero = 1'b0; b_preset = 32'd0;
      m_acc = 0; m_flags = 4'b0000;
      repeat (3) @(negedge clk);
      chk("rst_field", b_field, 32'd0);
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_flags", 32'(flags), 32'd0);

      // Ten up pulses, first tick 100 cycles after release
      reset = 1'b0; enable = 1'b1; c0 = cyc;
      repeat (10) pulse(1'b1, 1'b0, 1'b0);
      wait_start(300, cs);
      chk("first_tick", 32'(cs - c0), 32'd100);
      chk("ten_up_field", b_field, 32'(m_acc));
      @(negedge clk);
      chk("start_width", 32'(start), 32'd0);
      chk("busy_in_hs", 32'(busy), 32'd1);
      prev = cs;

      // Random up/down trains between ticks
      for (int r = 0; r < 6; r++) begin
         npulse = int'($urandom_range(1, 10));
         for (int k = 0; k < npulse; k++) begin
            u = 1'($urandom_range(0, 1));
            pulse(u, !u, 1'b0);
         end
         wait_start(300, cs);
         chk("tick_period", 32'(cs - prev), 32'd100);
         chk("rnd_field", b_field, 32'(m_acc));
         chk("rnd_flags", 32'(flags), 32'(m_flags));
         prev = cs;
      end

      // Preset then underflow, with prescaler held while disabled
      wait_idle();
      enable = 1'b0;
      do_clear();
      b_preset = 32'd100;
      pulse(1'b0, 1'b0, 1'b1);
      pulse(1'b0, 1'b1, 1'b0);
      enable = 1'b1; c0 = cyc;
      wait_start(300, cs);
      chk("reenable_tick", 32'(cs - c0), 32'd100);
      chk("udf_field", b_field, 32'(m_acc));
      chk("udf_flags", 32'(flags), 32'(m_flags));
      do_clear();
      chk("clear_flags", 32'(flags), 32'(m_flags));
      prev = cs;

      // Saturation at the top
      b_preset = 32'hFFFF_FF00;
      pulse(1'b0, 1'b0, 1'b1);
      pulse(1'b1, 1'b0, 1'b0);
      wait_start(300, cs);
      chk("ovf_period", 32'(cs - prev), 32'd100);
      chk("ovf_field", b_field, 32'(m_acc));
      chk("ovf_flags", 32'(flags), 32'(m_flags));
      prev = cs;
      pulse(1'b1, 1'b0, 1'b0);
      wait_start(300, cs);
      chk("ovf_hold_field", b_field, 32'(m_acc));
      prev = cs;

      // Coincident edges
      pulse(1'b1, 1'b1, 1'b0);
      wait_start(300, cs);
      chk("updn_field", b_field, 32'(m_acc));
      b_preset = 32'd5000;
      pulse(1'b1, 1'b0, 1'b1);
      wait_start(300, cs);
      chk("zero_up_field", b_field, 32'(m_acc));
      prev = cs;

      // Ready stuck high: WAIT_LOW times out
      repeat (20) @(negedge clk);
      do_clear();
      rsp_mode = 1;
      wait_start(300, cs);
      chk("stuck1_period", 32'(cs - prev), 32'd100);
      wait_tmo(100, tc);
      chk("stuck1_tmo_time", 32'(tc - cs), 32'd64);
      chk("stuck1_idle", 32'(busy), 32'd0);
      m_flags[3] = 1'b1;
      chk("stuck1_flags", 32'(flags), 32'(m_flags));
      prev = cs;
      wait_start(300, cs);
      chk("after_tmo_period", 32'(cs - prev), 32'd100);
      prev = cs;

      // Ready stuck low: WAIT_HIGH times out one cycle later
      repeat (70) @(negedge clk);
      do_clear();
      rsp_mode = 2;
      wait_start(300, cs);
      chk("stuck0_period", 32'(cs - prev), 32'd100);
      wait_tmo(100, tc);
      chk("stuck0_tmo_time", 32'(tc - cs), 32'd65);
      chk("stuck0_idle", 32'(busy), 32'd0);

      // Slow calculator spanning a tick: overrun, pending start after exit
      rsp_mode = 0; rsp_ack = 40; rsp_lat = 60;
      do_clear();
      prev = cs;
      wait_start(300, cs);
      chk("slow_period", 32'(cs - prev), 32'd100);
      prev = cs;
      wait_start(300, cs);
      chk("pending_start", 32'(cs - prev), 32'(rsp_ack + rsp_lat + 2));
      m_flags[2] = 1'b1;
      chk("overrun_flags", 32'(flags), 32'(m_flags));

      // Reset in the middle of WAIT_HIGH
      repeat (60) @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_start", 32'(start), 32'd0);
      chk("midrst_field", b_field, 32'd0);
      chk("midrst_flags", 32'(flags), 32'd0);
      m_acc = 0; m_flags = 4'b0000;
      rsp_ack = 0; rsp_lat = 11;
      @(negedge clk);
      reset = 1'b0; c0 = cyc;
      wait_start(300, cs);
      chk("post_rst_tick", 32'(cs - c0), 32'd100);
      chk("post_rst_field", b_field, 32'(m_acc));

      repeat (5) @(negedge clk);
      chk("start_pulse_width", 32'(width_err), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
